// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU.
// The bench or upstream block drives the master side, and alu_mc drives the slave side.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [3:0]       control;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             o_zf;
  logic             o_cf;
  logic             o_of;
  logic             busy;

  modport master (
    output in_valid, op1, op2, control,
    input  in_ready, out_valid, result, result_hi, o_zf, o_cf, o_of, busy
  );

  modport slave (
    input  in_valid, op1, op2, control,
    output in_ready, out_valid, result, result_hi, o_zf, o_cf, o_of, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU. Single-cycle logic ops, an iterative unsigned shift-add multiplier
// and an iterative unsigned restoring divider, with registered results and flags.
//
//   state | meaning
//   IDLE  | ready for a request (in_ready=1)
//   CALC  | one multiply/divide iteration per cycle, WIDTH cycles
//   DONE  | results valid for one cycle (out_valid=1)
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             zf_q, cf_q, of_q;

  logic             accept, is_multi, last_iter;
  logic [WIDTH:0]   add_sum, sub_dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_of;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign accept    = bus.in_valid && (state == IDLE);
  assign is_multi  = (bus.control == OP_MULU) || (bus.control == OP_DIVU);
  assign last_iter = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_multi ? CALC : DONE;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the ports on the accepting edge.
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    add_sum = {1'b0, bus.op1} + {1'b0, bus.op2};
    sub_dif = {1'b0, bus.op1} + {1'b0, ~bus.op2} + {{WIDTH{1'b0}}, 1'b1};
    case (bus.control)
      OP_AND: alu_res = bus.op1 & bus.op2;
      OP_OR:  alu_res = bus.op1 | bus.op2;
      OP_XOR: alu_res = bus.op1 ^ bus.op2;
      OP_NOR: alu_res = ~(bus.op1 | bus.op2);
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_cf  = add_sum[WIDTH];
        alu_of  = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                  (add_sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_dif[WIDTH-1:0];
        alu_cf  = ~sub_dif[WIDTH];
        alu_of  = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) &&
                  (sub_dif[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.op1 < bus.op2)};
      default: alu_res = '0;
    endcase
  end

  // One iteration step. The multiply and divide paths share acc_hi/acc_lo/opb.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    div_ok    = ~div_trial[WIDTH];
    if (op_div) begin
      hi_nxt = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_nxt = {acc_lo[WIDTH-2:0], div_ok};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      cnt         <= '0;
      op_div      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      if (accept) begin
        if (is_multi) begin
          op_div <= (bus.control == OP_DIVU);
          acc_hi <= '0;
          acc_lo <= (bus.control == OP_DIVU) ? bus.op1 : bus.op2;
          opb    <= (bus.control == OP_DIVU) ? bus.op2 : bus.op1;
          cnt    <= CW'(WIDTH - 1);
        end else begin
          result_q    <= alu_res;
          result_hi_q <= '0;
          zf_q        <= (alu_res == '0);
          cf_q        <= alu_cf;
          of_q        <= alu_of;
        end
      end else if (state == CALC) begin
        acc_hi <= hi_nxt;
        acc_lo <= lo_nxt;
        cnt    <= cnt - 1'b1;
        if (last_iter) begin
          result_q    <= lo_nxt;
          result_hi_q <= hi_nxt;
          zf_q        <= (lo_nxt == '0);
          cf_q        <= 1'b0;
          of_q        <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == CALC);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.o_zf      = zf_q;
  assign bus.o_cf      = cf_q;
  assign bus.o_of      = of_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=32: a table of directed vectors plus random ones
// scored through a queue, and hand sequences for CALC blocking and reset abort.
module tb_alu_mc;

  localparam int W = 32;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zf;
    logic        cf;
    logic        of;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_lat;
  int   mon_exp_lat;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic vec_t model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    vec_t r;
    longint sa, sb_, sr;
    logic [63:0] p;
    r = '{ctl, a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (ctl)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b0011: r.res = a ^ b;
      4'b0100: r.res = ~(a | b);
      4'b0010: begin
        r.res = a + b;
        r.cf  = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF;
        sr    = sa + sb_;
        r.of  = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
      end
      4'b0110: begin
        r.res = a - b;
        r.cf  = a < b;
        sr    = sa - sb_;
        r.of  = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
      end
      4'b0111: r.res = (sa < sb_) ? 32'd1 : 32'd0;
      4'b0101: r.res = (a < b) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = {32'h0, a} * {32'h0, b};
        r.res = p[31:0];
        r.hi  = p[63:32];
      end
      4'b1001: begin
        if (b == 0) begin
          r.res = 32'hFFFF_FFFF;
          r.hi  = a;
        end else begin
          r.res = a / b;
          r.hi  = a % b;
        end
      end
      default: r.res = 32'h0;
    endcase
    r.zf = (r.res == 32'h0);
    return r;
  endfunction

  task automatic issue(input vec_t v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
    end
    bus.in_valid = 1'b1;
    bus.op1      = v.a;
    bus.op2      = v.b;
    bus.control  = v.ctl;
    @(posedge clk);
    #1;
    sb.push_back('{v, cycle});
    bus.in_valid = 1'b0;
    bus.op1      = $urandom;
    bus.op2      = $urandom;
    bus.control  = 4'($urandom);
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.result, bus.result_hi,
         bus.o_zf, bus.o_cf, bus.o_of} !== {1'b1, 1'b0, 1'b0, 64'h0, 3'b000}) begin
      errors++;
      $display("FAIL %s: got rdy=%b ov=%b busy=%b res=%h hi=%h zf=%b cf=%b of=%b, required rdy=1 others 0",
               name, bus.in_ready, bus.out_valid, bus.busy, bus.result, bus.result_hi,
               bus.o_zf, bus.o_cf, bus.o_of);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 result=%h, required no result", bus.result);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if ({bus.result, bus.result_hi, bus.o_zf, bus.o_cf, bus.o_of} !==
            {mon_e.v.res, mon_e.v.hi, mon_e.v.zf, mon_e.v.cf, mon_e.v.of}) begin
          errors++;
          $display("FAIL result ctl=%b a=%h b=%h: got res=%h hi=%h zf=%b cf=%b of=%b, required res=%h hi=%h zf=%b cf=%b of=%b",
                   mon_e.v.ctl, mon_e.v.a, mon_e.v.b, bus.result, bus.result_hi, bus.o_zf, bus.o_cf, bus.o_of,
                   mon_e.v.res, mon_e.v.hi, mon_e.v.zf, mon_e.v.cf, mon_e.v.of);
        end
        mon_lat     = cycle + 1 - mon_e.acyc;
        mon_exp_lat = (mon_e.v.ctl == 4'b1000 || mon_e.v.ctl == 4'b1001) ? W + 1 : 1;
        checks++;
        if (mon_lat != mon_exp_lat) begin
          errors++;
          $display("FAIL latency ctl=%b: got %0d cycles, required %0d", mon_e.v.ctl, mon_lat, mon_exp_lat);
        end
      end
    end
  end

  vec_t tbl[16];
  logic [3:0] ops[11];

  initial begin
    int guard;
    vec_t rv;

    tbl[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'b1001, 32'd100,       32'd7,         32'd14,        32'd2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b1001, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_000F, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{4'b1000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h1, 1'b1, 1'b0, 1'b0};
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011,
            4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1100};

    bus.in_valid = 1'b0;
    bus.op1      = '0;
    bus.op2      = '0;
    bus.control  = '0;

    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) issue(tbl[i]);

    for (int i = 0; i < 14; i++) begin
      rv = model(ops[$urandom_range(0, 10)], $urandom, (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom);
      issue(rv);
    end

    // MULU corner: CALC must block requests and ignore a stray in_valid.
    issue('{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.in_valid = 1'b1;
        bus.control  = 4'b0000;
      end
      if (i == 9) bus.in_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL calc_blocking cycle %0d: got busy=%b in_ready=%b, required busy=1 in_ready=0",
                 i, bus.busy, bus.in_ready);
      end
    end

    // DIVU aborted by reset at CALC cycle 10.
    issue('{4'b1001, 32'hDEAD_BEEF, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_abort");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(tbl[7]);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.result !== 32'h0000_F000 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL result_hold: got res=%h out_valid=%b, required res=0000f000 out_valid=0",
               bus.result, bus.out_valid);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits (legal values: 8 to 64, even).
REQ-002 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  in  1  operation request valid.
REQ-005 in_ready  out  1  block can accept a request; equals 1 exactly when the FSM is in IDLE.
REQ-006 op1, op2  in  WIDTH  operands, captured on accept.
REQ-007 control  in  4  operation code, captured on accept.
REQ-008 out_valid  out  1  one-cycle pulse marking result, result_hi and flags as new.
REQ-009 result  out  WIDTH  primary result: low product, or quotient.
REQ-010 result_hi  out  WIDTH  secondary result: high product, or remainder; 0 for other ops.
REQ-011 o_zf, o_cf, o_of  out  1 each  zero, carry/borrow and signed-overflow flags.
REQ-012 busy  out  1  high while in CALC.

Function
REQ-013 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; op1, op2 and control SHALL be latched, and the ports are don't-care afterwards.
REQ-014 Op codes SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT (signed)
- 0011 XOR
- 0100 NOR
- 0101 SLTU
- 1000 MULU
- 1001 DIVU
- all other codes ILLEGAL: result=0, result_hi=0, all flags 0 except o_zf=1.
REQ-015 FSM states SHALL be IDLE, CALC and DONE:
- IDLE to DONE on accepting a single-cycle or ILLEGAL op.
- IDLE to CALC on accepting MULU or DIVU.
- CALC to DONE after exactly WIDTH iterations.
- DONE to IDLE unconditionally.
REQ-016 out_valid SHALL be 1 exactly during the DONE cycle; results SHALL be registered and SHALL hold until the next DONE.
REQ-017 Latency: if accept occurs at edge k, out_valid SHALL rise after edge k+1 for single-cycle ops, and after edge k+WIDTH+1 for MULU/DIVU.
REQ-018 Throughput: a request SHALL be accepted no more often than once per 2 cycles for single-cycle ops, and once per WIDTH+2 cycles for MULU/DIVU.
REQ-019 ADD/SUB SHALL be computed at WIDTH+1 bits, with SUB = op1 + ~op2 + 1:
- ADD: o_cf = bit WIDTH.
- SUB: o_cf = 1 when op1 < op2 unsigned (borrow).
- o_of = signed overflow of the WIDTH-bit result.
- Wrap-around SHALL be modulo 2^WIDTH.
REQ-020 SLT/SLTU SHALL set result=1 or 0 in bit 0; for all non-ADD/SUB ops, o_cf=0 and o_of=0.
REQ-021 MULU SHALL be an unsigned shift-add, one partial product per CALC cycle; {result_hi,result} SHALL equal op1*op2 at 2*WIDTH bits.
REQ-022 DIVU SHALL be unsigned restoring division, one quotient bit per CALC cycle; result SHALL be the quotient and result_hi the remainder.
REQ-023 DIVU with op2=0 SHALL still take WIDTH cycles and SHALL give result = all ones and result_hi = op1; it SHALL not flag an error.
REQ-024 o_zf SHALL be 1 iff result == 0, ignoring result_hi, and SHALL update only in DONE.
REQ-025 Requests with in_valid=1 while in_ready=0 SHALL be ignored and SHALL not be queued.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold:
- FSM in IDLE.
- in_ready=1.
- out_valid=0 and busy=0.
- result=0 and result_hi=0.
- o_zf=0, o_cf=0, o_of=0.
- All internal shift and accumulator registers at 0.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; no out_valid SHALL follow, and the first accept after reset release SHALL behave as from power-up.
REQ-028 An accept SHALL not occur on the first rising edge after rst_n deasserts only if in_valid=0.

Verification (WIDTH=32)
REQ-029 ADD 0x7FFFFFFF + 0x00000001 -> one cycle later: out_valid=1, result=0x80000000, o_of=1, o_cf=0, o_zf=0.
REQ-030 SUB 0x00000005 - 0x00000005 -> result=0, o_zf=1, o_cf=0. SUB 0x3 - 0x5 -> result=0xFFFFFFFE, o_cf=1.
REQ-031 SLT 0xFFFFFFFF vs 0x00000001 -> result=1. SLTU with the same operands -> result=0.
REQ-032 MULU 0xFFFFFFFF * 0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result=0x00000001, result_hi=0xFFFFFFFE; in_ready=0 and busy=1 throughout CALC; an in_valid pulse during CALC is ignored.
REQ-033 DIVU 100/7 -> result=14, result_hi=2. DIVU 0x1234/0 -> result=0xFFFFFFFF, result_hi=0x1234, same latency.
REQ-034 DIVU accepted, rst_n pulsed low at CALC cycle 10 -> all outputs 0 immediately, no out_valid; a following AND 0xF0F0 & 0xFF00 -> result=0xF000.
